// File: rtl/fifo_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared definitions for the FIFO-drain UART transmitter and the future RX
// stage: FSM state encoding and default baud divisors for a 12 MHz clock.
// -----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // Clock cycles per bit at 12 MHz.
    localparam int BAUD_DIV_9600   = 1250;
    localparam int BAUD_DIV_115200 = 104;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read side of the byte-wide FIFO stack.
//   FIFO_data  : head row of the FIFO
//   FIFO_empty : FIFO holds no rows
//   FIFO_busy  : FIFO is mid-operation, must not be popped
//   FIFO_pop   : one-cycle pop strobe from the consumer
// master = FIFO side, slave = consumer (the UART drain stage).
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] FIFO_data;
    logic                  FIFO_empty;
    logic                  FIFO_busy;
    logic                  FIFO_pop;

    modport master (
        output FIFO_data,
        output FIFO_empty,
        output FIFO_busy,
        input  FIFO_pop
    );

    modport slave (
        input  FIFO_data,
        input  FIFO_empty,
        input  FIFO_busy,
        output FIFO_pop
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_baud_tick
// Loadable down-counter producing one bit period of BAUD_DIV cycles.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : restart the period (count <= BAUD_DIV-1)
//   tick       : high while the count is 0, i.e. the last cycle of a period
// The counter reloads itself at 0 instead of wrapping, so consecutive
// periods follow each other with no gap.
// -----------------------------------------------------------------------------
module fifo_uart_tx_baud_tick #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int            CW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains the byte FIFO one row at a time and sends each row as an 8N1/8N2
// UART frame, LSB first.
//   clk, rst_n : clock, async active-low reset
//   fifo       : FIFO read side (slave modport); this block is the only popper
//   TX_enable  : gates new pops only; a frame in flight always completes
//   TX         : serial line, idle high
//   TX_busy    : high from the pop cycle to the end of the last stop bit
// All outputs are registered.
//
// State | Meaning
// IDLE  | line high, waiting for enabled, non-empty, non-busy FIFO
// POP   | pop strobe cycle; head byte already captured
// START | start bit (low) for one bit period
// DATA  | DATA_WIDTH data bits, LSB first
// STOP  | STOP_BITS bit periods high, then back to IDLE
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_115200,
    parameter int STOP_BITS  = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_uart_tx_if.slave      fifo,
    input  logic               TX_enable,
    output logic               TX,
    output logic               TX_busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BW-1:0]         bit_cnt;
    logic                  baud_load;
    logic                  tick;

    // Start-bit period begins on the edge leaving POP.
    assign baud_load = (state == ST_POP);

    fifo_uart_tx_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (baud_load),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            TX            <= 1'b1;
            TX_busy       <= 1'b0;
            fifo.FIFO_pop <= 1'b0;
            shift         <= '0;
            bit_cnt       <= '0;
        end else begin
            fifo.FIFO_pop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Byte is captured on the same edge that raises pop,
                    // before the FIFO advances its head.
                    if (TX_enable && !fifo.FIFO_empty && !fifo.FIFO_busy) begin
                        fifo.FIFO_pop <= 1'b1;
                        TX_busy       <= 1'b1;
                        shift         <= fifo.FIFO_data;
                        state         <= ST_POP;
                    end
                end
                ST_POP: begin
                    TX    <= 1'b0;
                    state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        TX      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            TX      <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                        end else begin
                            TX      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // bit_cnt is reused to count stop-bit periods.
                    if (tick) begin
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            TX_busy <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two instances: dut_a (BAUD_DIV=4, 1 stop bit) and dut_b (BAUD_DIV=2,
// 2 stop bits). Bytes are pushed into sb_q as they are offered to the FIFO
// side and popped when a frame is decoded from TX.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int BD_A = 4;
    localparam int SB_A = 1;
    localparam int BD_B = 2;
    localparam int SB_B = 2;

    logic clk;
    logic rst_n;
    logic en_a, en_b;
    logic tx_a, tx_b;
    logic busy_a, busy_b;
    logic sel;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fa ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fb ();

    fifo_uart_tx #(.BAUD_DIV(BD_A), .STOP_BITS(SB_A), .DATA_WIDTH(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo      (fa.slave),
        .TX_enable (en_a),
        .TX        (tx_a),
        .TX_busy   (busy_a)
    );

    fifo_uart_tx #(.BAUD_DIV(BD_B), .STOP_BITS(SB_B), .DATA_WIDTH(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo      (fb.slave),
        .TX_enable (en_b),
        .TX        (tx_b),
        .TX_busy   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] sb_q[$];

    logic tx_s, busy_s, pop_s;
    assign tx_s   = sel ? tx_b   : tx_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign pop_s  = sel ? fb.FIFO_pop : fa.FIFO_pop;

    // Pop counting and single-cycle pop width, sampled on the falling edge.
    int   pops_a = 0, pops_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if (fa.FIFO_pop === 1'b1) begin
            pops_a++;
            n_assert++;
            assert (prev_a !== 1'b1) else begin
                n_fail++;
                $error("FAIL pop_width_a: observed 2+ consecutive pop cycles, expected 1");
            end
        end
        if (fb.FIFO_pop === 1'b1) begin
            pops_b++;
            n_assert++;
            assert (prev_b !== 1'b1) else begin
                n_fail++;
                $error("FAIL pop_width_b: observed 2+ consecutive pop cycles, expected 1");
            end
        end
        prev_a = fa.FIFO_pop;
        prev_b = fb.FIFO_pop;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Advance until pop is seen (bounded); reports cycles waited.
    task automatic wait_pop(input int max_cyc, output int waited);
        waited = 0;
        while (pop_s !== 1'b1 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        chk("pop_seen", pop_s, 1);
        chk("busy_at_pop", busy_s, 1);
    endtask

    // Decode one frame and check every cycle of it against the scoreboard.
    task automatic recv_frame(input int bd, input int sb, input int drop_en_at);
        int         waited;
        int         bad;
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       eb;
        waited = 0;
        while (tx_s !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("start_bit", tx_s, 0);
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
        bad = 0;
        got = '0;
        for (int i = 0; i < 9 + sb; i++) begin
            if (i == 0)      eb = 1'b0;
            else if (i <= 8) eb = exp_b[i-1];
            else             eb = 1'b1;
            for (int c = 0; c < bd; c++) begin
                if (i * bd + c == drop_en_at) en_a = 1'b0;
                if (tx_s !== eb || busy_s !== 1'b1) bad++;
                if (i >= 1 && i <= 8 && c == bd / 2) got[i-1] = tx_s;
                @(negedge clk);
            end
        end
        chk("frame_shape", bad, 0);
        chk("byte", got, exp_b);
        chk("busy_fall", busy_s, 0);
        chk("tx_idle", tx_s, 1);
    endtask

    initial begin
        int w;
        int bad;
        int exp_pops_a;
        exp_pops_a = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        fa.FIFO_data = 8'h00; fa.FIFO_empty = 1'b1; fa.FIFO_busy = 1'b0;
        fb.FIFO_data = 8'h00; fb.FIFO_empty = 1'b1; fb.FIFO_busy = 1'b0;

        // Reset state
        cycles(3);
        chk("rst_tx", tx_a, 1);
        chk("rst_pop", fa.FIFO_pop, 0);
        chk("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || fa.FIFO_pop !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("idle_100", bad, 0);

        // Single byte A5: latency, exact bit sequence, 41 busy cycles
        fa.FIFO_data = 8'hA5; fa.FIFO_empty = 1'b0; sb_q.push_back(8'hA5);
        wait_pop(5, w);
        exp_pops_a++;
        chk("pop_latency", w, 1);
        fa.FIFO_empty = 1'b1;
        @(negedge clk);
        chk("pop_one_cycle", pop_s, 0);
        chk("tx_fall_latency", tx_s, 0);
        recv_frame(BD_A, SB_A, -1);
        cycles(10);
        chk("pops_single", pops_a, exp_pops_a);

        // Back-to-back 00 then FF
        fa.FIFO_data = 8'h00; fa.FIFO_empty = 1'b0;
        sb_q.push_back(8'h00); sb_q.push_back(8'hFF);
        wait_pop(5, w);
        exp_pops_a++;
        fa.FIFO_data = 8'hFF;
        recv_frame(BD_A, SB_A, -1);
        wait_pop(3, w);
        exp_pops_a++;
        chk("b2b_gap", w, 1);
        fa.FIFO_empty = 1'b1;
        recv_frame(BD_A, SB_A, -1);
        cycles(10);
        chk("pops_b2b", pops_a, exp_pops_a);

        // Busy gating, busy rising together with empty falling
        fa.FIFO_data = 8'h5A; fa.FIFO_busy = 1'b1; fa.FIFO_empty = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pop_s !== 1'b0) bad++;
        end
        chk("no_pop_while_busy", bad, 0);
        fa.FIFO_busy = 1'b0; sb_q.push_back(8'h5A);
        wait_pop(5, w);
        exp_pops_a++;
        chk("pop_after_busy", w, 1);
        fa.FIFO_empty = 1'b1;
        recv_frame(BD_A, SB_A, -1);

        // TX_enable falls during bit 3, FIFO still non-empty
        fa.FIFO_data = 8'hC3; fa.FIFO_empty = 1'b0; sb_q.push_back(8'hC3);
        wait_pop(5, w);
        exp_pops_a++;
        fa.FIFO_data = 8'h11;
        recv_frame(BD_A, SB_A, 4 * BD_A + 1);
        cycles(40);
        chk("pops_en_low", pops_a, exp_pops_a);
        chk("tx_en_low", tx_s, 1);
        chk("busy_en_low", busy_s, 0);
        fa.FIFO_empty = 1'b1;
        en_a = 1'b1;
        cycles(2);

        // Reset pulse during bit 5 of 96 (bit 5 = 0)
        fa.FIFO_data = 8'h96; fa.FIFO_empty = 1'b0;
        wait_pop(5, w);
        exp_pops_a++;
        fa.FIFO_empty = 1'b1;
        @(negedge clk);
        cycles(6 * BD_A + 1);
        chk("pre_rst_tx", tx_s, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx_s, 1);
        chk("rst_async_busy", busy_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(30);
        chk("pops_after_rst", pops_a, exp_pops_a);
        chk("tx_after_rst", tx_s, 1);
        chk("busy_after_rst", busy_s, 0);

        // Recovers cleanly from IDLE after the reset
        fa.FIFO_data = 8'h3A; fa.FIFO_empty = 1'b0; sb_q.push_back(8'h3A);
        wait_pop(5, w);
        exp_pops_a++;
        chk("pop_latency_rec", w, 1);
        fa.FIFO_empty = 1'b1;
        recv_frame(BD_A, SB_A, -1);
        cycles(10);
        chk("pops_total_a", pops_a, exp_pops_a);

        // Two stop bits, BAUD_DIV=2, byte 3C: 22-cycle frame
        sel = 1'b1;
        fb.FIFO_data = 8'h3C; fb.FIFO_empty = 1'b0; sb_q.push_back(8'h3C);
        wait_pop(5, w);
        chk("pop_latency_b", w, 1);
        fb.FIFO_empty = 1'b1;
        recv_frame(BD_B, SB_B, -1);
        cycles(10);
        chk("pops_total_b", pops_b, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
